// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init/refresh states, mode word.
package sdram_pkg;

   // {CS_N, RAS_N, CAS_N, WE_N}
   typedef enum logic [3:0] {
      CMD_MRS  = 4'b0000,
      CMD_REF  = 4'b0001,
      CMD_PALL = 4'b0010,
      CMD_ACT  = 4'b0011,
      CMD_WR   = 4'b0100,
      CMD_RD   = 4'b0101,
      CMD_NOP  = 4'b0111
   } sdram_cmd_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PWRUP,
      S_PRE,
      S_TRP,
      S_REF,
      S_TRFC,
      S_LOAD,
      S_TMRD,
      S_READY,
      S_RPRE,
      S_RTRP,
      S_RREF,
      S_RTRFC
   } sdram_init_state_t;

   localparam int A10_BIT = 10;

   function automatic logic [15:0] mode_word(
      input logic       wb_single,
      input logic [2:0] cas_lat,
      input logic [2:0] bl_code
   );
      return {6'd0, wb_single, 2'b00, cas_lat, 1'b0, bl_code};
   endfunction

endpackage

// File: rtl/sdram_cycle_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module sdram_cycle_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic        zero
);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != 16'd0) begin
         cnt <= cnt - 16'd1;
      end
   end

   assign zero = (cnt == 16'd0);

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer and periodic auto-refresh engine with arbiter handshake.
module sdram_init_refresh
   import sdram_pkg::*;
#(
   parameter int T_PWRUP_CYC = 10000,
   parameter int N_INIT_REF  = 8,
   parameter int T_RP_CYC    = 2,
   parameter int T_RFC_CYC   = 7,
   parameter int T_MRD_CYC   = 2,
   parameter int T_REFI_CYC  = 780,
   parameter int MAX_PEND    = 4,
   parameter int CAS_LAT     = 2,
   parameter int BL_CODE     = 3,
   parameter int WB_SINGLE   = 1,
   parameter int ADDR_W      = 13
) (
   input  logic              iclk,
   input  logic              ireset_n,
   input  logic              ireq,
   input  logic              ienb,
   input  logic              iref_gnt,
   output logic              ofin,
   output logic              oref_req,
   output logic              oref_busy,
   output logic              oref_overrun,
   output logic              DRAM_CLK,
   output logic              DRAM_CKE,
   output logic              DRAM_CS_N,
   output logic              DRAM_RAS_N,
   output logic              DRAM_CAS_N,
   output logic              DRAM_WE_N,
   output logic [ADDR_W-1:0] DRAM_ADDR,
   output logic [1:0]        DRAM_BA,
   output logic              DRAM_UDQM,
   output logic              DRAM_LDQM,
   output logic [15:0]       DRAM_DQ
);

   localparam logic [15:0] LD_PWRUP = 16'(T_PWRUP_CYC - 1);
   localparam logic [15:0] LD_RP    = 16'(T_RP_CYC - 1);
   localparam logic [15:0] LD_RFC   = 16'(T_RFC_CYC - 1);
   localparam logic [15:0] LD_MRD   = 16'(T_MRD_CYC - 1);
   localparam logic [15:0] LD_REFI  = 16'(T_REFI_CYC - 1);

   localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(1) << A10_BIT;
   localparam logic [ADDR_W-1:0] ADDR_MODE = ADDR_W'(mode_word(
      1'(WB_SINGLE), 3'(CAS_LAT), 3'(BL_CODE)));

   sdram_init_state_t  state;
   sdram_cmd_t         cmd;
   logic [ADDR_W-1:0]  addr;
   logic               cke;
   logic [1:0]         dqm;
   logic               fin;
   logic               busy;
   logic               overrun;
   logic [2:0]         backlog;
   logic [3:0]         refs_done;

   logic               w_load;
   logic [15:0]        w_val;
   logic               w_zero;
   logic               i_active;
   logic               i_tick;
   logic               i_zero;
   logic               in_rref;

   // Each command state preloads the wait that follows it.
   always_comb begin
      w_load = 1'b1;
      w_val  = '0;
      case (state)
         S_IDLE:          w_val = LD_PWRUP;
         S_PRE, S_RPRE:   w_val = LD_RP;
         S_REF, S_RREF:   w_val = LD_RFC;
         S_LOAD:          w_val = LD_MRD;
         default:         w_load = 1'b0;
      endcase
   end

   sdram_cycle_timer u_wait (
      .clk      (iclk),
      .rst_n    (ireset_n),
      .load     (w_load),
      .load_val (w_val),
      .zero     (w_zero)
   );

   assign i_active = state inside {S_READY, S_RPRE, S_RTRP, S_RREF, S_RTRFC};
   assign i_tick   = i_active && i_zero;
   assign in_rref  = (state == S_RREF);

   sdram_cycle_timer u_refi (
      .clk      (iclk),
      .rst_n    (ireset_n),
      .load     (!i_active || i_tick),
      .load_val (LD_REFI),
      .zero     (i_zero)
   );

   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state     <= S_IDLE;
         cmd       <= CMD_NOP;
         addr      <= '0;
         cke       <= 1'b0;
         dqm       <= 2'b11;
         fin       <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         backlog   <= '0;
         refs_done <= '0;
      end else begin
         cmd  <= CMD_NOP;
         addr <= '0;
         unique case (state)
            S_IDLE: if (ireq) begin
               state <= S_PWRUP;
               cke   <= 1'b1;
            end
            S_PWRUP: if (w_zero) begin
               state <= S_PRE;
               cmd   <= CMD_PALL;
               addr  <= ADDR_A10;
            end
            S_PRE: state <= S_TRP;
            S_TRP: if (w_zero) begin
               state <= S_REF;
               cmd   <= CMD_REF;
            end
            S_REF: begin
               state     <= S_TRFC;
               refs_done <= refs_done + 4'd1;
            end
            S_TRFC: if (w_zero) begin
               if (refs_done < 4'(N_INIT_REF)) begin
                  state <= S_REF;
                  cmd   <= CMD_REF;
               end else begin
                  state <= S_LOAD;
                  cmd   <= CMD_MRS;
                  addr  <= ADDR_MODE;
               end
            end
            S_LOAD: state <= S_TMRD;
            S_TMRD: if (w_zero) begin
               state <= S_READY;
               fin   <= 1'b1;
               dqm   <= 2'b00;
            end
            S_READY: if (oref_req && iref_gnt) begin
               state <= S_RPRE;
               cmd   <= CMD_PALL;
               addr  <= ADDR_A10;
               busy  <= 1'b1;
            end
            S_RPRE: state <= S_RTRP;
            S_RTRP: if (w_zero) begin
               state <= S_RREF;
               cmd   <= CMD_REF;
            end
            S_RREF: state <= S_RTRFC;
            S_RTRFC: if (w_zero) begin
               state <= S_READY;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase

         // A tick landing on the refresh command cancels out.
         if (i_tick && !in_rref) begin
            if (backlog == 3'(MAX_PEND)) overrun <= 1'b1;
            else backlog <= backlog + 3'd1;
         end else if (!i_tick && in_rref) begin
            backlog <= backlog - 3'd1;
         end
      end
   end

   assign ofin         = fin;
   assign oref_busy    = busy;
   assign oref_overrun = overrun;
   assign oref_req     = (backlog != 3'd0) && (state == S_READY);

   assign DRAM_CLK   = ienb ? ~iclk   : 1'bz;
   assign DRAM_CKE   = ienb ? cke     : 1'bz;
   assign DRAM_CS_N  = ienb ? cmd[3]  : 1'bz;
   assign DRAM_RAS_N = ienb ? cmd[2]  : 1'bz;
   assign DRAM_CAS_N = ienb ? cmd[1]  : 1'bz;
   assign DRAM_WE_N  = ienb ? cmd[0]  : 1'bz;
   assign DRAM_ADDR  = ienb ? addr    : {ADDR_W{1'bz}};
   assign DRAM_BA    = ienb ? 2'b00   : 2'bzz;
   assign DRAM_UDQM  = ienb ? dqm[1]  : 1'bz;
   assign DRAM_LDQM  = ienb ? dqm[0]  : 1'bz;
   assign DRAM_DQ    = ienb ? 16'h0   : {16{1'bz}};

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench: command scoreboard plus timed checks of init and refresh handshake.
module tb_sdram_init_refresh;

   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] PALL = 4'b0010;
   localparam logic [3:0] REF  = 4'b0001;
   localparam logic [3:0] MRS  = 4'b0000;

   typedef struct {
      logic [3:0]  cmd;
      logic [12:0] addr;
      bit          care;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        ireset_n;
   logic        ireq;
   logic        ienb;
   logic        gnt;
   wire         ofin;
   wire         oref_req;
   wire         oref_busy;
   wire         oref_overrun;
   wire         DRAM_CLK;
   wire         DRAM_CKE;
   wire         DRAM_CS_N;
   wire         DRAM_RAS_N;
   wire         DRAM_CAS_N;
   wire         DRAM_WE_N;
   wire  [12:0] DRAM_ADDR;
   wire  [1:0]  DRAM_BA;
   wire         DRAM_UDQM;
   wire         DRAM_LDQM;
   wire  [15:0] DRAM_DQ;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q[$];
   exp_t e;
   logic [3:0] cmd_now;
   int   c0, p, m, r, c1;

   sdram_init_refresh #(
      .T_PWRUP_CYC (20),
      .T_REFI_CYC  (50)
   ) dut (
      .iclk         (clk),
      .ireset_n     (ireset_n),
      .ireq         (ireq),
      .ienb         (ienb),
      .iref_gnt     (gnt),
      .ofin         (ofin),
      .oref_req     (oref_req),
      .oref_busy    (oref_busy),
      .oref_overrun (oref_overrun),
      .DRAM_CLK     (DRAM_CLK),
      .DRAM_CKE     (DRAM_CKE),
      .DRAM_CS_N    (DRAM_CS_N),
      .DRAM_RAS_N   (DRAM_RAS_N),
      .DRAM_CAS_N   (DRAM_CAS_N),
      .DRAM_WE_N    (DRAM_WE_N),
      .DRAM_ADDR    (DRAM_ADDR),
      .DRAM_BA      (DRAM_BA),
      .DRAM_UDQM    (DRAM_UDQM),
      .DRAM_LDQM    (DRAM_LDQM),
      .DRAM_DQ      (DRAM_DQ)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push(input logic [3:0] c, input logic [12:0] a,
                       input bit care, input int when);
      exp_t x;
      x.cmd  = c;
      x.addr = a;
      x.care = care;
      x.cyc  = when;
      q.push_back(x);
   endtask

   // Scoreboard: every non-NOP command must match the next expected one.
   always @(negedge clk) begin
      if (ireset_n && ienb) begin
         if (q.size() > 0) begin
            n_chk++;
            assert (q[0].cyc >= cyc) else begin
               n_fail++;
               $error("FAIL missed_cmd: observed none expected %b at %0d",
                      q[0].cmd, q[0].cyc);
               void'(q.pop_front());
            end
         end
         cmd_now = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
         if (cmd_now !== NOP) begin
            n_chk++;
            assert (q.size() > 0) else begin
               n_fail++;
               $error("FAIL stray_cmd: observed %b at %0d expected NOP",
                      cmd_now, cyc);
            end
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("cmd_code", 32'(cmd_now), 32'(e.cmd));
               chk("cmd_cycle", cyc, e.cyc);
               if (e.care) chk("cmd_addr", 32'(DRAM_ADDR), 32'(e.addr));
            end
         end
      end
   end

   initial begin
      ireset_n = 1'b0;
      ireq     = 1'b0;
      ienb     = 1'b1;
      gnt      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd", {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}, NOP);
      chk("rst_cke", DRAM_CKE, 0);
      chk("rst_dqm", {DRAM_UDQM, DRAM_LDQM}, 2'b11);
      chk("rst_addr", DRAM_ADDR, 0);
      chk("rst_ba", DRAM_BA, 0);
      chk("rst_flags", {ofin, oref_req, oref_busy, oref_overrun}, 0);

      ireset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_cke", DRAM_CKE, 0);

      // Init: PWRUP entered the cycle after ireq is seen.
      ireq = 1'b1;
      c0 = cyc + 1;
      p  = c0 + 20;
      push(PALL, 13'h0400, 1'b1, p);
      for (int k = 0; k < 8; k++) push(REF, 13'h0, 1'b0, p + 3 + 8 * k);
      m = p + 3 + 7 * 8 + 8;
      push(MRS, 13'h0223, 1'b1, m);
      @(negedge clk);
      ireq = 1'b0;
      chk("pwrup_cke", DRAM_CKE, 1);
      chk("pwrup_fin", ofin, 0);
      at(m + 2);
      chk("tmrd_fin", ofin, 0);
      at(m + 3);
      chk("ready_fin", ofin, 1);
      chk("ready_dqm", {DRAM_UDQM, DRAM_LDQM}, 2'b00);
      r = m + 3;

      // First periodic request, granted three cycles later.
      at(r + 49);
      chk("refi_req_early", oref_req, 0);
      at(r + 50);
      chk("refi_req", oref_req, 1);
      at(r + 53);
      push(PALL, 13'h0400, 1'b1, r + 54);
      push(REF, 13'h0, 1'b0, r + 57);
      gnt = 1'b1;
      at(r + 54);
      gnt = 1'b0;
      chk("rpre_req", oref_req, 0);
      chk("rpre_busy", oref_busy, 1);
      at(r + 64);
      chk("rtrfc_busy", oref_busy, 1);
      at(r + 65);
      chk("ref_done_busy", oref_busy, 0);
      chk("ref_done_req", oref_req, 0);
      at(r + 99);
      chk("refi2_req_early", oref_req, 0);
      at(r + 100);
      chk("refi2_req", oref_req, 1);

      // Starve the engine until the backlog overflows.
      at(r + 299);
      chk("ovr_early", oref_overrun, 0);
      at(r + 300);
      chk("ovr_set", oref_overrun, 1);
      for (int k = 0; k < 4; k++) begin
         push(PALL, 13'h0400, 1'b1, r + 301 + 12 * k);
         push(REF, 13'h0, 1'b0, r + 304 + 12 * k);
      end
      gnt = 1'b1;
      at(r + 337);
      gnt = 1'b0;
      at(r + 348);
      chk("drain_req", oref_req, 0);
      chk("drain_busy", oref_busy, 0);
      chk("drain_ovr", oref_overrun, 1);
      at(r + 350);
      chk("post_drain_req", oref_req, 1);

      // Reset during tRFC of a refresh.
      push(PALL, 13'h0400, 1'b1, r + 351);
      push(REF, 13'h0, 1'b0, r + 354);
      gnt = 1'b1;
      at(r + 351);
      gnt = 1'b0;
      at(r + 356);
      #1 ireset_n = 1'b0;
      #1;
      chk("abort_cmd", {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N}, NOP);
      chk("abort_cke", DRAM_CKE, 0);
      chk("abort_dqm", {DRAM_UDQM, DRAM_LDQM}, 2'b11);
      chk("abort_flags", {ofin, oref_req, oref_busy, oref_overrun}, 0);
      chk("abort_queue", q.size(), 0);

      ienb = 1'b0;
      #1;
      n_chk++;
      assert (DRAM_CKE === 1'bz) else begin
         n_fail++; $error("FAIL z_cke: observed %b expected z", DRAM_CKE);
      end
      n_chk++;
      assert (DRAM_CLK === 1'bz) else begin
         n_fail++; $error("FAIL z_clk: observed %b expected z", DRAM_CLK);
      end
      n_chk++;
      assert (DRAM_CS_N === 1'bz) else begin
         n_fail++; $error("FAIL z_cs: observed %b expected z", DRAM_CS_N);
      end
      n_chk++;
      assert (DRAM_ADDR === 13'bz) else begin
         n_fail++; $error("FAIL z_addr: observed %h expected z", DRAM_ADDR);
      end
      n_chk++;
      assert (DRAM_DQ === 16'bz) else begin
         n_fail++; $error("FAIL z_dq: observed %h expected z", DRAM_DQ);
      end
      ienb = 1'b1;
      #1;
      chk("enb_dq", DRAM_DQ, 0);

      // Restart from PWRUP after reset.
      @(negedge clk);
      ireset_n = 1'b1;
      @(negedge clk);
      ireq = 1'b1;
      c1 = cyc + 1;
      push(PALL, 13'h0400, 1'b1, c1 + 20);
      push(REF, 13'h0, 1'b0, c1 + 23);
      @(negedge clk);
      ireq = 1'b0;
      chk("restart_cke", DRAM_CKE, 1);
      at(c1 + 24);
      chk("restart_queue", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
